jtframe_bank_reader: RTL and testbench



---
 rtl/jtframe_bank_reader_if.sv | 29 ++
 rtl/jtframe_bank_reader.sv | 95 +++++++++
 tb/tb_jtframe_bank_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_bank_reader_if.sv
// Client slot plus SDRAM bank read-port signals for one jtframe bank reader.
// master = the reader itself, slave = the client/controller environment.
interface jtframe_bank_reader_if #(
  parameter int AW     = 20,
  parameter int DW     = 8,
  parameter int SDRAMW = 22
);
  logic [AW-1:0]     slot_addr;
  logic              slot_cs;
  logic              slot_ok;
  logic [DW-1:0]     slot_dout;
  logic [SDRAMW-1:0] ba_addr;
  logic              ba_rd;
  logic              ba_ack;
  logic              ba_dst;
  logic              ba_dok;
  logic              ba_rdy;
  logic [15:0]       data_read;

  modport master (
    input  slot_addr, slot_cs, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
    output slot_ok, slot_dout, ba_addr, ba_rd
  );

  modport slave (
    output slot_addr, slot_cs, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
    input  slot_ok, slot_dout, ba_addr, ba_rd
  );
endinterface

// File: rtl/jtframe_bank_reader.sv
// Caches one 32-bit SDRAM line for a client slot; hits answer 1 cycle after the address settles.
// Misses hold ba_rd until ba_ack; a started burst always runs to ba_rdy, no new request while flush=1.
module jtframe_bank_reader #(
  parameter int                AW     = 20,
  parameter int                DW     = 8,
  parameter int                SDRAMW = 22,
  parameter logic [SDRAMW-1:0] OFFSET = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  jtframe_bank_reader_if.master bus
);
  localparam int SH = (DW == 8) ? 2 : (DW == 16) ? 1 : 0;
  localparam int IW = AW - SH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]        state;
  logic [IW-1:0]     cur_idx;
  logic [IW-1:0]     line_idx;
  logic              line_vld;
  logic              discard;
  logic [31:0]       line_dat;
  logic [1:0]        wcnt;
  logic [1:0]        eff_cnt;
  logic [1:0]        sel;
  logic              hit;
  logic [SDRAMW-1:0] req_addr;
  logic [DW-1:0]     dout_nxt;

  assign cur_idx  = bus.slot_addr[AW-1:SH];
  assign hit      = line_vld && (line_idx == cur_idx);
  assign sel      = 2'(bus.slot_addr) & 2'((1 << SH) - 1);
  assign dout_nxt = DW'(line_dat >> (32'(sel) * DW));
  assign req_addr = OFFSET + SDRAMW'({cur_idx, 1'b0});
  // A burst-start word always lands in the low half, whatever the counter says.
  assign eff_cnt  = bus.ba_dst ? 2'd0 : wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      line_idx      <= '0;
      line_vld      <= 1'b0;
      discard       <= 1'b0;
      line_dat      <= '0;
      wcnt          <= '0;
      bus.slot_ok   <= 1'b0;
      bus.slot_dout <= '0;
      bus.ba_addr   <= '0;
      bus.ba_rd     <= 1'b0;
    end else begin
      bus.slot_ok   <= bus.slot_cs & hit & ~flush;
      bus.slot_dout <= dout_nxt;
      if (flush) line_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.slot_cs && !hit && !flush) begin
            // The line is overwritten by the coming burst, so it stops being valid now.
            line_idx    <= cur_idx;
            line_vld    <= 1'b0;
            discard     <= 1'b0;
            bus.ba_addr <= req_addr;
            bus.ba_rd   <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (flush) discard <= 1'b1;
          if (bus.ba_ack) begin
            bus.ba_rd <= 1'b0;
            wcnt      <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (flush) discard <= 1'b1;
          if (bus.ba_dok && !eff_cnt[1]) begin
            if (eff_cnt[0]) line_dat[31:16] <= bus.data_read;
            else            line_dat[15:0]  <= bus.data_read;
            wcnt <= eff_cnt + 2'd1;
          end
          if (bus.ba_rdy) begin
            line_vld <= ~(discard | flush);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtframe_bank_reader.sv
// Directed and randomized bench for jtframe_bank_reader: a DW=16 instance against a
// one-line cache model with a synthetic SDRAM, and a DW=8 instance for byte selection.
module tb_jtframe_bank_reader;
  localparam logic [21:0] OFF16 = 22'h100000;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic flush  = 1'b0;
  logic flush8 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  jtframe_bank_reader_if #(.AW(20), .DW(16), .SDRAMW(22)) b16 ();
  jtframe_bank_reader_if #(.AW(20), .DW(8),  .SDRAMW(22)) b8 ();

  jtframe_bank_reader #(.AW(20), .DW(16), .SDRAMW(22), .OFFSET(OFF16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b16)
  );
  jtframe_bank_reader #(.AW(20), .DW(8), .SDRAMW(22), .OFFSET(22'h0)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(b8)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Synthetic SDRAM contents: any word address maps to a scrambled 16-bit value.
  function automatic logic [15:0] mem(input logic [21:0] w);
    logic [21:0] p;
    p = w * 22'd40503;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  // Controller side of one burst; entered at a negedge with ba_rd asserted.
  // mode 1 pulses flush on the first data word, mode 2 moves slot_addr there.
  task automatic serve16(input int dly, input logic [15:0] w0, input logic [15:0] w1,
                         input int mode, input logic [19:0] new_addr);
    repeat (dly) tick;
    b16.ba_ack = 1'b1; tick; b16.ba_ack = 1'b0;
    tick;
    b16.ba_dst = 1'b1; b16.ba_dok = 1'b1; b16.data_read = w0;
    if (mode == 1) flush = 1'b1;
    if (mode == 2) b16.slot_addr = new_addr;
    tick;
    flush = 1'b0;
    b16.ba_dst = 1'b0; b16.data_read = w1; b16.ba_rdy = 1'b1;
    tick;
    b16.ba_dok = 1'b0; b16.ba_rdy = 1'b0; b16.data_read = '0;
  endtask

  initial begin
    logic [21:0] a0;
    logic [21:0] ew;
    logic [31:0] ln;
    logic [18:0] m_idx;
    logic        m_vld;
    int          a;

    b16.slot_addr = '0; b16.slot_cs = 1'b0; b16.ba_ack = 1'b0; b16.ba_dst = 1'b0;
    b16.ba_dok = 1'b0; b16.ba_rdy = 1'b0; b16.data_read = '0;
    b8.slot_addr = '0; b8.slot_cs = 1'b0; b8.ba_ack = 1'b0; b8.ba_dst = 1'b0;
    b8.ba_dok = 1'b0; b8.ba_rdy = 1'b0; b8.data_read = '0;

    repeat (3) @(negedge clk);
    chk("rst_ok", 32'(b16.slot_ok), 0);
    chk("rst_rd", 32'(b16.ba_rd), 0);
    chk("rst_addr", 32'(b16.ba_addr), 0);
    chk("rst_dout", 32'(b16.slot_dout), 0);
    rst_n = 1'b1;
    tick;

    // Miss then hit on the same line
    b16.slot_addr = 20'h5; b16.slot_cs = 1'b1;
    tick;
    chk("t1_rd", 32'(b16.ba_rd), 1);
    chk("t1_addr", 32'(b16.ba_addr), 32'h100004);
    serve16(3, 16'h1111, 16'h2222, 0, '0);
    chk("t1_ok_pre", 32'(b16.slot_ok), 0);
    tick;
    chk("t1_ok", 32'(b16.slot_ok), 1);
    chk("t1_dout", 32'(b16.slot_dout), 32'h2222);
    b16.slot_addr = 20'h4;
    tick;
    chk("t1_hit_ok", 32'(b16.slot_ok), 1);
    chk("t1_hit_dout", 32'(b16.slot_dout), 32'h1111);
    chk("t1_hit_rd", 32'(b16.ba_rd), 0);

    // Byte selection on the DW=8 instance
    b8.slot_addr = 20'h0; b8.slot_cs = 1'b1;
    tick;
    chk("b8_rd", 32'(b8.ba_rd), 1);
    chk("b8_addr", 32'(b8.ba_addr), 0);
    b8.ba_ack = 1'b1; tick; b8.ba_ack = 1'b0;
    b8.ba_dst = 1'b1; b8.ba_dok = 1'b1; b8.data_read = 16'h1100; tick;
    b8.ba_dst = 1'b0; b8.data_read = 16'h3322; b8.ba_rdy = 1'b1; tick;
    b8.ba_dok = 1'b0; b8.ba_rdy = 1'b0;
    ln = 32'h3322_1100;
    for (int i = 0; i < 4; i++) begin
      b8.slot_addr = 20'(i);
      tick;
      chk("b8_ok", 32'(b8.slot_ok), 1);
      chk("b8_dout", 32'(b8.slot_dout), 32'(ln[8*i +: 8]));
    end

    // Delayed ack with slot_cs toggling
    b16.slot_addr = 20'h40;
    tick;
    chk("dly_rd0", 32'(b16.ba_rd), 1);
    a0 = b16.ba_addr;
    chk("dly_addr0", 32'(a0), 32'(OFF16 + 22'h40));
    for (int i = 0; i < 50; i++) begin
      if (i % 7 == 3) b16.slot_cs = ~b16.slot_cs;
      tick;
      chk("dly_rd", 32'(b16.ba_rd), 1);
      chk("dly_addr", 32'(b16.ba_addr), 32'(a0));
      chk("dly_ok", 32'(b16.slot_ok), 0);
    end
    b16.slot_cs = 1'b1;
    serve16(0, mem(a0), mem(a0 + 22'd1), 0, '0);
    tick;
    chk("dly_ok_end", 32'(b16.slot_ok), 1);
    chk("dly_dout", 32'(b16.slot_dout), 32'(mem(OFF16 + 22'h40)));

    // Address moves to another line mid-fetch
    b16.slot_addr = 20'h10;
    tick;
    chk("mv_rd", 32'(b16.ba_rd), 1);
    chk("mv_addr", 32'(b16.ba_addr), 32'(OFF16 + 22'h10));
    serve16(1, mem(OFF16 + 22'h10), mem(OFF16 + 22'h11), 2, 20'h21);
    chk("mv_ok_idle", 32'(b16.slot_ok), 0);
    chk("mv_rd_idle", 32'(b16.ba_rd), 0);
    tick;
    chk("mv_rd2", 32'(b16.ba_rd), 1);
    chk("mv_addr2", 32'(b16.ba_addr), 32'(OFF16 + 22'h20));
    chk("mv_ok2", 32'(b16.slot_ok), 0);
    serve16(2, mem(OFF16 + 22'h20), mem(OFF16 + 22'h21), 0, '0);
    chk("mv_ok3", 32'(b16.slot_ok), 0);
    tick;
    chk("mv_ok4", 32'(b16.slot_ok), 1);
    chk("mv_dout", 32'(b16.slot_dout), 32'(mem(OFF16 + 22'h21)));

    // Flush of a valid line, then flush during a fetch
    flush = 1'b1;
    tick;
    chk("fl_ok", 32'(b16.slot_ok), 0);
    chk("fl_rd", 32'(b16.ba_rd), 0);
    flush = 1'b0;
    tick;
    chk("fl_rd2", 32'(b16.ba_rd), 1);
    chk("fl_addr", 32'(b16.ba_addr), 32'(OFF16 + 22'h20));
    serve16(0, mem(OFF16 + 22'h20), mem(OFF16 + 22'h21), 1, '0);
    chk("fl_rd_idle", 32'(b16.ba_rd), 0);
    tick;
    chk("fl_refetch", 32'(b16.ba_rd), 1);
    chk("fl_ok_disc", 32'(b16.slot_ok), 0);
    serve16(0, mem(OFF16 + 22'h20), mem(OFF16 + 22'h21), 0, '0);
    tick;
    chk("fl_ok_end", 32'(b16.slot_ok), 1);
    chk("fl_dout", 32'(b16.slot_dout), 32'(mem(OFF16 + 22'h21)));

    // Random accesses against a one-line cache model
    m_idx = 19'h10;
    m_vld = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a = int'($urandom_range(0, 31));
      b16.slot_addr = 20'(a);
      if ($urandom_range(0, 3) == 0) begin
        b16.slot_cs = 1'b0;
        tick;
        chk("rnd_cs_off", 32'(b16.slot_ok), 0);
        b16.slot_cs = 1'b1;
      end
      tick;
      ew = OFF16 + 22'(a);
      if (m_vld && m_idx == 19'(a / 2)) begin
        chk("rnd_hit_rd", 32'(b16.ba_rd), 0);
        chk("rnd_hit_ok", 32'(b16.slot_ok), 1);
        chk("rnd_hit_dout", 32'(b16.slot_dout), 32'(mem(ew)));
      end else begin
        chk("rnd_miss_rd", 32'(b16.ba_rd), 1);
        chk("rnd_miss_addr", 32'(b16.ba_addr), 32'(OFF16 + 22'(a - a % 2)));
        serve16(int'($urandom_range(0, 4)), mem(OFF16 + 22'(a - a % 2)),
                mem(OFF16 + 22'(a - a % 2 + 1)), 0, '0);
        tick;
        chk("rnd_fill_ok", 32'(b16.slot_ok), 1);
        chk("rnd_fill_dout", 32'(b16.slot_dout), 32'(mem(ew)));
        m_idx = 19'(a / 2);
        m_vld = 1'b1;
      end
    end

    // Asynchronous reset while a request is pending
    b16.slot_addr = 20'h77;
    tick;
    chk("ar_rd_pre", 32'(b16.ba_rd), 1);
    chk("ar_ok8_pre", 32'(b8.slot_ok), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rd", 32'(b16.ba_rd), 0);
    chk("ar_ok", 32'(b16.slot_ok), 0);
    chk("ar_ok8", 32'(b8.slot_ok), 0);
    chk("ar_addr", 32'(b16.ba_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("ar_fresh_rd", 32'(b16.ba_rd), 1);
    chk("ar_fresh_addr", 32'(b16.ba_addr), 32'(OFF16 + 22'h76));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
